kbd_playback_cmd: RTL and testbench

// - Upstream of the lab2 playback controller: turns keyboard ASCII events into registered

---
 rtl/lab2_cmd_pkg.sv | 31 +++
 rtl/rise_edge_detect.sv | 19 +
 rtl/kbd_playback_cmd.sv | 99 +++++++++
 tb/tb_kbd_playback_cmd.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lab2_cmd_pkg.sv
// rtl/lab2_cmd_pkg.sv - shared command codes and restart state type for the lab2 playback path
package lab2_cmd_pkg;

   localparam logic [7:0] CMD_PLAY      = 8'h45;
   localparam logic [7:0] CMD_PAUSE     = 8'h44;
   localparam logic [7:0] CMD_FWD       = 8'h46;
   localparam logic [7:0] CMD_BWD       = 8'h42;
   localparam logic [7:0] CMD_RESTART   = 8'h52;
   localparam logic [7:0] CMD_FASTER    = 8'h55;
   localparam logic [7:0] CMD_SLOWER    = 8'h4C;
   localparam logic [7:0] CMD_SPEED_RST = 8'h4B;

   typedef enum logic {
      R_IDLE,
      R_PEND
   } restart_state_t;

   function automatic logic [7:0] ascii_upper(input logic [7:0] c);
      if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
      return c;
   endfunction

   function automatic logic is_cmd(input logic [7:0] c);
      case (c)
         CMD_PLAY, CMD_PAUSE, CMD_FWD, CMD_BWD,
         CMD_RESTART, CMD_FASTER, CMD_SLOWER, CMD_SPEED_RST: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// rtl/rise_edge_detect.sv - one-cycle strobe on the first cycle a level input is seen high
module rise_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic pulse
);

   logic din_d;

   // Cleared by reset, so a level held across reset release yields a fresh strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) din_d <= 1'b0;
      else     din_d <= din;
   end

   assign pulse = din & ~din_d;

endmodule

// File: rtl/kbd_playback_cmd.sv
// rtl/kbd_playback_cmd.sv - keyboard ASCII events to registered playback controls
module kbd_playback_cmd
   import lab2_cmd_pkg::*;
#(
   parameter int SPEED_W       = 4,
   parameter int SPEED_DEFAULT = 4,
   parameter int SPEED_MIN     = 1,
   parameter int SPEED_MAX     = 15
) (
   input  logic               CLK_50M,
   input  logic               rst,
   input  logic [7:0]         kbd_received_ascii_code,
   input  logic               kbd_data_ready,
   input  logic               restart_ack,
   output logic               play,
   output logic               direction_fwd,
   output logic               restart_req,
   output logic [SPEED_W-1:0] speed_div,
   output logic               cmd_valid,
   output logic [7:0]         last_cmd,
   output logic [7:0]         bad_cmd_cnt
);

   if (SPEED_MIN > SPEED_DEFAULT || SPEED_DEFAULT > SPEED_MAX) begin : g_bad_speed
      $error("kbd_playback_cmd: need SPEED_MIN <= SPEED_DEFAULT <= SPEED_MAX");
   end

   localparam logic [SPEED_W-1:0] SP_DEF = SPEED_W'(SPEED_DEFAULT);
   localparam logic [SPEED_W-1:0] SP_MIN = SPEED_W'(SPEED_MIN);
   localparam logic [SPEED_W-1:0] SP_MAX = SPEED_W'(SPEED_MAX);
   localparam logic [SPEED_W-1:0] SP_ONE = SPEED_W'(1);

   logic           kbd_event;
   logic [7:0]     code_uc;
   logic           known;
   restart_state_t r_state, r_next;

   rise_edge_detect u_ready_edge (
      .clk   (CLK_50M),
      .rst   (rst),
      .din   (kbd_data_ready),
      .pulse (kbd_event)
   );

   assign code_uc = ascii_upper(kbd_received_ascii_code);
   assign known   = is_cmd(code_uc);

   always_ff @(posedge CLK_50M or posedge rst) begin
      if (rst) begin
         play          <= 1'b1;
         direction_fwd <= 1'b1;
         speed_div     <= SP_DEF;
         cmd_valid     <= 1'b0;
         last_cmd      <= 8'h00;
         bad_cmd_cnt   <= 8'h00;
      end else begin
         cmd_valid <= 1'b0;
         if (kbd_event) begin
            if (known) begin
               cmd_valid <= 1'b1;
               last_cmd  <= code_uc;
               case (code_uc)
                  CMD_PLAY:      play          <= 1'b1;
                  CMD_PAUSE:     play          <= 1'b0;
                  CMD_FWD:       direction_fwd <= 1'b1;
                  CMD_BWD:       direction_fwd <= 1'b0;
                  CMD_FASTER:    if (speed_div > SP_MIN) speed_div <= speed_div - SP_ONE;
                  CMD_SLOWER:    if (speed_div < SP_MAX) speed_div <= speed_div + SP_ONE;
                  CMD_SPEED_RST: speed_div     <= SP_DEF;
                  default:       ;
               endcase
            end else if (bad_cmd_cnt != 8'hFF) begin
               bad_cmd_cnt <= bad_cmd_cnt + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge CLK_50M or posedge rst) begin
      if (rst) r_state <= R_IDLE;
      else     r_state <= r_next;
   end

   // A new 'R' outranks an ack on the same edge so the fresh request is never lost.
   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE: if (kbd_event && code_uc == CMD_RESTART) r_next = R_PEND;
         R_PEND: begin
            if (kbd_event && code_uc == CMD_RESTART) r_next = R_PEND;
            else if (restart_ack)                    r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   assign restart_req = (r_state == R_PEND);

endmodule

// File: tb/tb_kbd_playback_cmd.sv
// tb/tb_kbd_playback_cmd.sv - self-checking bench for kbd_playback_cmd
module tb_kbd_playback_cmd;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] code = 8'h00;
   logic       rdy = 1'b0;
   logic       ack = 1'b0;
   logic       play, direction_fwd, restart_req, cmd_valid;
   logic [3:0] speed_div;
   logic [7:0] last_cmd, bad_cmd_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // reference state
   bit  m_play, m_fwd, m_pend, m_valid, m_prev;
   int  m_speed, m_bad;
   byte unsigned m_last;

   kbd_playback_cmd dut (
      .CLK_50M                 (clk),
      .rst                     (rst),
      .kbd_received_ascii_code (code),
      .kbd_data_ready          (rdy),
      .restart_ack             (ack),
      .play                    (play),
      .direction_fwd           (direction_fwd),
      .restart_req             (restart_req),
      .speed_div               (speed_div),
      .cmd_valid               (cmd_valid),
      .last_cmd                (last_cmd),
      .bad_cmd_cnt             (bad_cmd_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_play = 1; m_fwd = 1; m_pend = 0; m_valid = 0; m_prev = 0;
      m_speed = 4; m_bad = 0; m_last = 8'h00;
   endfunction

   function automatic void model_edge(input byte unsigned c, input bit r, input bit a);
      bit ev;
      byte unsigned u;
      bit rec;
      ev = r && !m_prev;
      m_prev = r;
      u = (c >= "a" && c <= "z") ? c - 8'd32 : c;
      rec = 1;
      m_valid = 0;
      if (ev) begin
         case (u)
            "E": m_play = 1;
            "D": m_play = 0;
            "F": m_fwd = 1;
            "B": m_fwd = 0;
            "R": ;
            "U": m_speed = (m_speed - 1 < 1) ? 1 : m_speed - 1;
            "L": m_speed = (m_speed + 1 > 15) ? 15 : m_speed + 1;
            "K": m_speed = 4;
            default: rec = 0;
         endcase
         if (rec) begin
            m_valid = 1;
            m_last = u;
         end else if (m_bad < 255) begin
            m_bad++;
         end
      end
      if (ev && u == "R") m_pend = 1;
      else if (a)         m_pend = 0;
   endfunction

   task automatic compare_model();
      check("play", int'(play), int'(m_play));
      check("direction_fwd", int'(direction_fwd), int'(m_fwd));
      check("restart_req", int'(restart_req), int'(m_pend));
      check("speed_div", int'(speed_div), m_speed);
      check("cmd_valid", int'(cmd_valid), int'(m_valid));
      check("last_cmd", int'(last_cmd), int'(m_last));
      check("bad_cmd_cnt", int'(bad_cmd_cnt), m_bad);
   endtask

   task automatic step(input logic [7:0] c, input logic r, input logic a);
      code = c; rdy = r; ack = a;
      @(posedge clk);
      model_edge(c, r, a);
      #1;
      compare_model();
   endtask

   task automatic press(input logic [7:0] c);
      step(c, 1'b1, 1'b0);
      step(c, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1; rdy = 1'b0; ack = 1'b0; code = 8'h00;
      #1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_play"}, int'(play), 1);
      check({tag, "_fwd"}, int'(direction_fwd), 1);
      check({tag, "_req"}, int'(restart_req), 0);
      check({tag, "_speed"}, int'(speed_div), 4);
      check({tag, "_valid"}, int'(cmd_valid), 0);
      check({tag, "_last"}, int'(last_cmd), 0);
      check({tag, "_bad"}, int'(bad_cmd_cnt), 0);
   endtask

   typedef struct {
      logic [7:0] code;
      logic       rdy;
      logic [3:0] speed;
      logic       valid;
      logic [7:0] last;
      logic [7:0] bad;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int pulses;
      int req_hi;
      logic [7:0] pool [12];

      vecs.push_back('{8'h55, 1'b1, 4'd3, 1'b1, 8'h55, 8'd0});
      vecs.push_back('{8'h55, 1'b1, 4'd3, 1'b0, 8'h55, 8'd0});
      vecs.push_back('{8'h55, 1'b0, 4'd3, 1'b0, 8'h55, 8'd0});
      vecs.push_back('{8'h75, 1'b1, 4'd2, 1'b1, 8'h55, 8'd0});
      vecs.push_back('{8'h75, 1'b0, 4'd2, 1'b0, 8'h55, 8'd0});
      vecs.push_back('{8'h55, 1'b1, 4'd1, 1'b1, 8'h55, 8'd0});
      vecs.push_back('{8'h55, 1'b0, 4'd1, 1'b0, 8'h55, 8'd0});
      vecs.push_back('{8'h55, 1'b1, 4'd1, 1'b1, 8'h55, 8'd0});
      vecs.push_back('{8'h55, 1'b0, 4'd1, 1'b0, 8'h55, 8'd0});
      vecs.push_back('{8'h55, 1'b1, 4'd1, 1'b1, 8'h55, 8'd0});
      vecs.push_back('{8'h55, 1'b0, 4'd1, 1'b0, 8'h55, 8'd0});
      vecs.push_back('{8'h6B, 1'b1, 4'd4, 1'b1, 8'h4B, 8'd0});
      vecs.push_back('{8'h6B, 1'b0, 4'd4, 1'b0, 8'h4B, 8'd0});
      vecs.push_back('{8'h31, 1'b1, 4'd4, 1'b0, 8'h4B, 8'd1});
      vecs.push_back('{8'h31, 1'b0, 4'd4, 1'b0, 8'h4B, 8'd1});
      vecs.push_back('{8'h7A, 1'b1, 4'd4, 1'b0, 8'h4B, 8'd2});
      vecs.push_back('{8'h7A, 1'b0, 4'd4, 1'b0, 8'h4B, 8'd2});

      // reset and idle
      do_reset();
      repeat (5) step(8'h00, 1'b0, 1'b0);
      check_reset_values("idle");

      // 'D' held for 20 cycles gives one command, then 'e'
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         step("D", 1'b1, 1'b0);
         pulses += int'(cmd_valid);
      end
      check("held_pulses", pulses, 1);
      check("held_play", int'(play), 0);
      step("D", 1'b0, 1'b0);
      press("e");
      check("e_play", int'(play), 1);
      check("e_last", int'(last_cmd), 8'h45);

      // 'B', 'R', ack late
      press("B");
      check("b_fwd", int'(direction_fwd), 0);
      step("R", 1'b1, 1'b0);
      req_hi = int'(restart_req);
      for (int i = 0; i < 9; i++) begin
         step("R", 1'b0, 1'b0);
         req_hi += int'(restart_req);
      end
      check("req_hi_cycles", req_hi, 10);
      check("r_keeps_fwd", int'(direction_fwd), 0);
      step(8'h00, 1'b0, 1'b1);
      check("req_after_ack", int'(restart_req), 0);
      step(8'h00, 1'b0, 1'b0);

      // 'R' event coincides with ack
      press("r");
      step("R", 1'b1, 1'b1);
      check("r_and_ack", int'(restart_req), 1);
      step("R", 1'b0, 1'b1);
      check("second_ack", int'(restart_req), 0);
      step(8'h00, 1'b0, 1'b1);
      check("ack_in_idle", int'(restart_req), 0);

      // table: 'U' floor, 'K', unrecognised codes
      do_reset();
      foreach (vecs[i]) begin
         step(vecs[i].code, vecs[i].rdy, 1'b0);
         check($sformatf("vec%0d_speed", i), int'(speed_div), int'(vecs[i].speed));
         check($sformatf("vec%0d_valid", i), int'(cmd_valid), int'(vecs[i].valid));
         check($sformatf("vec%0d_last", i), int'(last_cmd), int'(vecs[i].last));
         check($sformatf("vec%0d_bad", i), int'(bad_cmd_cnt), int'(vecs[i].bad));
      end

      // 'L' ceiling then 'K'
      for (int i = 0; i < 20; i++) press("L");
      check("l_ceiling", int'(speed_div), 15);
      press("K");
      check("k_default", int'(speed_div), 4);

      // reset while a restart is pending, ready held across release
      press("D");
      step("R", 1'b1, 1'b0);
      check("pre_rst_req", int'(restart_req), 1);
      #2;
      rst = 1'b1;
      #1;
      check_reset_values("async_rst");
      model_reset();
      code = "D";
      rst = 1'b0;
      step("D", 1'b1, 1'b0);
      check("post_rst_event", int'(cmd_valid), 1);
      check("post_rst_play", int'(play), 0);
      step("D", 1'b0, 1'b0);

      // randomized against the reference model
      pool = '{"E", "D", "F", "B", "R", "U", "L", "K", "e", "u", "l", "1"};
      for (int i = 0; i < 600; i++) begin
         logic [7:0] c;
         if ($urandom_range(0, 3) == 0) c = 8'($urandom);
         else                           c = pool[$urandom_range(0, 11)];
         step(c, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
